// File: rtl/ahb_fifo_sink_if.sv
// AHB slave-slot bundle for ahb_fifo_sink: shared bus inputs plus the per-slot
// HRDATA/HRESP/HREADY returns.
interface ahb_fifo_sink_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADYin;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        HREADYout;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
    output HRDATA, HRESP, HREADYout
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYin,
    input  HRDATA, HRESP, HREADYout
  );
endinterface

// File: rtl/ahb_fifo_sink.sv
// AHB write sink: DATA writes fill a FIFO drained on a valid/ready stream; full
// writes stall. AHB_FIFO_SINK_TIMEOUT_EN adds the stall timeout, ERROR response and ovf.
module ahb_fifo_sink #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahb_fifo_sink_if.slave ahb,
  output logic           OUT_VALID,
  output logic [31:0]    OUT_DATA,
  input  logic           OUT_READY
);

  localparam int unsigned         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [1:0]          HRESP_OKAY  = 2'b00;
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
  localparam logic [1:0]          HRESP_ERROR = 2'b01;
`endif

  typedef enum logic [2:0] {
    IDLE,
    XFER,
    WAIT_FULL
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
    ,
    ERR1,
    ERR2
`endif
  } state_t;

  state_t                state;
  logic [1:0]            dp_addr;
  logic                  dp_write;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovf_bit;
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
  logic [7:0]            stall_cnt;
  logic                  ovf;
  assign ovf_bit = ovf;
`else
  assign ovf_bit = 1'b0;
`endif

  logic        addr_ok;
  logic        empty;
  logic        full;
  logic        pop;
  logic        space;
  logic        push;
  logic        flush;
  logic        hready;
  logic [1:0]  resp;
  logic [31:0] rdata;
  logic [31:0] status_word;
  logic        unused_inputs;

  assign unused_inputs = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HTRANS[0],
                           ahb.HSIZE, ahb.HBURST};

  assign addr_ok     = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADYin;
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign pop         = !empty && OUT_READY;
  assign space       = !full || pop;
  assign status_word = {13'd0, ovf_bit, full, empty, 16'(count)};

  always_comb begin
    push   = 1'b0;
    flush  = 1'b0;
    hready = 1'b1;
    resp   = HRESP_OKAY;
    rdata  = '0;
    case (state)
      XFER: begin
        if (dp_write && dp_addr == 2'd0) begin
          push   = space;
          hready = space;
        end
        if (dp_write && dp_addr == 2'd2) flush = ahb.HWDATA[0];
        if (!dp_write && dp_addr == 2'd1) rdata = status_word;
      end
      WAIT_FULL: begin
        push   = space;
        hready = space;
      end
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
      ERR1: begin
        hready = 1'b0;
        resp   = HRESP_ERROR;
      end
      ERR2: resp = HRESP_ERROR;
`endif
      default: ;
    endcase
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HRESP     = resp;
  assign ahb.HREADYout = hready;

  // Any cycle with HREADYout=1 ends the current data phase, so the pipelined
  // address decision is shared by every completing state.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= IDLE;
      dp_addr  <= '0;
      dp_write <= 1'b0;
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
      stall_cnt <= '0;
      ovf       <= 1'b0;
`endif
    end else begin
      if (hready) begin
        state <= addr_ok ? XFER : IDLE;
        if (addr_ok) begin
          dp_addr  <= ahb.HADDR[3:2];
          dp_write <= ahb.HWRITE;
        end
      end else begin
        case (state)
          XFER: begin
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
            stall_cnt <= '0;
            if (TIMEOUT <= 1) begin
              state <= ERR1;
              ovf   <= 1'b1;
            end else begin
              state <= WAIT_FULL;
            end
`else
            state <= WAIT_FULL;
`endif
          end
          WAIT_FULL: begin
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
            // The stalled XFER cycle is the first wait state, hence the +2.
            if (int'(stall_cnt) + 2 >= TIMEOUT) begin
              state <= ERR1;
              ovf   <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 8'd1;
            end
`endif
          end
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
          ERR1: state <= ERR2;
`endif
          default: state <= IDLE;
        endcase
      end
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
      if (flush) ovf <= 1'b0;
`endif
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= ahb.HWDATA;
  end

  assign OUT_VALID = !empty;
  assign OUT_DATA  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_ahb_fifo_sink.sv
// Directed bench for ahb_fifo_sink (DEPTH_LOG2=2, TIMEOUT=4): per-cycle vector
// table plus wrap-around and asynchronous-reset sequences.
module tb_ahb_fifo_sink;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NS  = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic        ordy;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        vld;
    logic [31:0] odata;
  } vec_t;

  logic        HCLK;
  logic        HRESET;
  logic        OUT_VALID;
  logic [31:0] OUT_DATA;
  logic        OUT_READY;

  ahb_fifo_sink_if bus ();
  assign bus.HREADYin = bus.HREADYout;

  ahb_fifo_sink #(.DEPTH_LOG2(2), .TIMEOUT(4)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .ahb       (bus),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .OUT_READY (OUT_READY)
  );

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  logic [31:0] exp_q[$];
  logic        s_rdy;
  logic [31:0] s_rdata;
  logic [31:0] flush_head;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic sel, input logic [1:0] tr, input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic ordy, input logic rdy, input logic [1:0] resp,
                     input logic [31:0] rdata, input logic vld, input logic [31:0] odata);
    vec_t r;
    r.sel = sel; r.trans = tr; r.wr = wr; r.addr = a; r.wd = wd; r.ordy = ordy;
    r.rdy = rdy; r.resp = resp; r.rdata = rdata; r.vld = vld; r.odata = odata;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic wr, input logic [3:0] a,
                       input logic [31:0] wd);
    bus.HSEL   = sel;
    bus.HTRANS = tr;
    bus.HWRITE = wr;
    bus.HADDR  = {28'h4000000, a};
    bus.HWDATA = wd;
  endtask

  task automatic step(input int idx, input vec_t r);
    drive(r.sel, r.trans, r.wr, r.addr, r.wd);
    OUT_READY = r.ordy;
    @(negedge HCLK);
    chk($sformatf("row%0d HREADYout", idx), 32'(bus.HREADYout), 32'(r.rdy));
    chk($sformatf("row%0d HRESP", idx), 32'(bus.HRESP), 32'(r.resp));
    chk($sformatf("row%0d HRDATA", idx), bus.HRDATA, r.rdata);
    chk($sformatf("row%0d OUT_VALID", idx), 32'(OUT_VALID), 32'(r.vld));
    if (r.vld) chk($sformatf("row%0d OUT_DATA", idx), OUT_DATA, r.odata);
    @(posedge HCLK);
    #1;
  endtask

  // One cycle with random consumer readiness; stream pops are scored against exp_q.
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr, input logic [3:0] a,
                     input logic [31:0] wd, input logic force_rdy);
    drive(sel, tr, wr, a, wd);
    OUT_READY = force_rdy ? 1'b1 : 1'($urandom_range(0, 1));
    @(negedge HCLK);
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wrap pop: got 0x%08h with nothing expected", OUT_DATA);
      end else begin
        chk("wrap order", OUT_DATA, exp_q.pop_front());
      end
    end
    s_rdy   = bus.HREADYout;
    s_rdata = bus.HRDATA;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic [31:0] wv;
    int n;
    logic done;

    HRESET = 1'b1;
    drive(1'b0, IDL, 1'b0, 4'h0, '0);
    bus.HSIZE  = 3'b010;
    bus.HBURST = 3'b000;
    OUT_READY  = 1'b0;

`ifdef AHB_FIFO_SINK_TIMEOUT_EN
    flush_head = 32'hB0;
`else
    flush_head = 32'hB1;
`endif

    // status read and three back-to-back writes, then drain
    add(1, NS, 0, 4'h4, 0,      0, 1, 0, 0, 0, 0);
    add(0, IDL, 0, 4'h0, 0,     0, 1, 0, 32'h0001_0000, 0, 0);
    add(1, NS, 1, 4'h0, 0,      0, 1, 0, 0, 0, 0);
    add(1, SQ, 1, 4'h0, 32'h11, 0, 1, 0, 0, 0, 0);
    add(1, SQ, 1, 4'h0, 32'h22, 0, 1, 0, 0, 1, 32'h11);
    add(1, NS, 0, 4'h4, 32'h33, 0, 1, 0, 0, 1, 32'h11);
    add(0, IDL, 0, 4'h0, 0,     0, 1, 0, 32'h3, 1, 32'h11);
    add(0, IDL, 0, 4'h0, 0,     1, 1, 0, 0, 1, 32'h11);
    add(0, IDL, 0, 4'h0, 0,     1, 1, 0, 0, 1, 32'h22);
    add(0, IDL, 0, 4'h0, 0,     1, 1, 0, 0, 1, 32'h33);
    // fill to 4, fifth write stalls 3 cycles until the consumer pops
    add(1, NS, 1, 4'h0, 0,      0, 1, 0, 0, 0, 0);
    add(1, SQ, 1, 4'h0, 32'hA0, 0, 1, 0, 0, 0, 0);
    add(1, SQ, 1, 4'h0, 32'hA1, 0, 1, 0, 0, 1, 32'hA0);
    add(1, SQ, 1, 4'h0, 32'hA2, 0, 1, 0, 0, 1, 32'hA0);
    add(1, SQ, 1, 4'h0, 32'hA3, 0, 1, 0, 0, 1, 32'hA0);
    add(0, IDL, 0, 4'h0, 32'hA4, 0, 0, 0, 0, 1, 32'hA0);
    add(0, IDL, 0, 4'h0, 32'hA4, 0, 0, 0, 0, 1, 32'hA0);
    add(0, IDL, 0, 4'h0, 32'hA4, 0, 0, 0, 0, 1, 32'hA0);
    add(0, IDL, 0, 4'h0, 32'hA4, 1, 1, 0, 0, 1, 32'hA0);
    add(0, IDL, 0, 4'h0, 0,     1, 1, 0, 0, 1, 32'hA1);
    add(0, IDL, 0, 4'h0, 0,     1, 1, 0, 0, 1, 32'hA2);
    add(0, IDL, 0, 4'h0, 0,     1, 1, 0, 0, 1, 32'hA3);
    add(0, IDL, 0, 4'h0, 0,     1, 1, 0, 0, 1, 32'hA4);
    add(0, IDL, 0, 4'h0, 0,     0, 1, 0, 0, 0, 0);
    // push into empty FIFO with OUT_READY high: not forwarded that cycle
    add(1, NS, 1, 4'h0, 0,      1, 1, 0, 0, 0, 0);
    add(0, IDL, 0, 4'h0, 32'h77, 1, 1, 0, 0, 0, 0);
    add(0, IDL, 0, 4'h0, 0,     1, 1, 0, 0, 1, 32'h77);
    add(0, IDL, 0, 4'h0, 0,     0, 1, 0, 0, 0, 0);
    // reserved/DATA/CONTROL reads, unselected and IDLE writes: no side effects
    add(1, NS, 1, 4'hC, 0,       0, 1, 0, 0, 0, 0);
    add(1, NS, 0, 4'hC, 32'hDEAD, 0, 1, 0, 0, 0, 0);
    add(1, NS, 0, 4'h0, 0,       0, 1, 0, 0, 0, 0);
    add(0, NS, 1, 4'h0, 0,       0, 1, 0, 0, 0, 0);
    add(1, IDL, 1, 4'h0, 32'h55, 0, 1, 0, 0, 0, 0);
    add(1, NS, 0, 4'h8, 32'h66,  0, 1, 0, 0, 0, 0);
    add(1, NS, 0, 4'h4, 0,       0, 1, 0, 0, 0, 0);
    add(0, IDL, 0, 4'h0, 0,      0, 1, 0, 32'h0001_0000, 0, 0);
    // full FIFO, write with consumer stalled
    add(1, NS, 1, 4'h0, 0,      0, 1, 0, 0, 0, 0);
    add(1, SQ, 1, 4'h0, 32'hB0, 0, 1, 0, 0, 0, 0);
    add(1, SQ, 1, 4'h0, 32'hB1, 0, 1, 0, 0, 1, 32'hB0);
    add(1, SQ, 1, 4'h0, 32'hB2, 0, 1, 0, 0, 1, 32'hB0);
    add(1, SQ, 1, 4'h0, 32'hB3, 0, 1, 0, 0, 1, 32'hB0);
    add(0, IDL, 0, 4'h0, 32'hB4, 0, 0, 0, 0, 1, 32'hB0);
    add(0, IDL, 0, 4'h0, 32'hB4, 0, 0, 0, 0, 1, 32'hB0);
    add(0, IDL, 0, 4'h0, 32'hB4, 0, 0, 0, 0, 1, 32'hB0);
    add(0, IDL, 0, 4'h0, 32'hB4, 0, 0, 0, 0, 1, 32'hB0);
`ifdef AHB_FIFO_SINK_TIMEOUT_EN
    add(0, IDL, 0, 4'h0, 32'hB4, 0, 0, 1, 0, 1, 32'hB0);
    add(1, NS, 0, 4'h4, 32'hB4,  0, 1, 1, 0, 1, 32'hB0);
    add(0, IDL, 0, 4'h0, 0,      0, 1, 0, 32'h0006_0004, 1, 32'hB0);
`else
    add(0, IDL, 0, 4'h0, 32'hB4, 0, 0, 0, 0, 1, 32'hB0);
    add(1, NS, 0, 4'h4, 32'hB4,  1, 1, 0, 0, 1, 32'hB0);
    add(0, IDL, 0, 4'h0, 0,      0, 1, 0, 32'h0002_0004, 1, 32'hB1);
`endif
    // flush while full, with a pop in the same cycle
    add(1, NS, 1, 4'h8, 0,      0, 1, 0, 0, 1, flush_head);
    add(0, IDL, 0, 4'h0, 32'h1, 1, 1, 0, 0, 1, flush_head);
    add(1, NS, 0, 4'h4, 0,      0, 1, 0, 0, 0, 0);
    add(0, IDL, 0, 4'h0, 0,     0, 1, 0, 32'h0001_0000, 0, 0);

    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("reset HREADYout", 32'(bus.HREADYout), 32'h1);
    chk("reset HRESP", 32'(bus.HRESP), 32'h0);
    chk("reset HRDATA", bus.HRDATA, 32'h0);
    chk("reset OUT_VALID", 32'(OUT_VALID), 32'h0);
    chk("reset OUT_DATA", OUT_DATA, 32'h0);
    @(posedge HCLK);
    #1;

    for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

    // pointer wrap: 3*depth words with random consumer readiness
    for (int i = 0; i < 12; i++) begin
      wv = 32'hC0DE_0000 + 32'(i);
      cyc(1'b1, NS, 1'b1, 4'h0, '0, 1'b0);
      n = 0;
      done = 1'b0;
      while (!done && n < 30) begin
        cyc(1'b0, IDL, 1'b0, 4'h0, wv, n >= 2);
        if (s_rdy) begin
          exp_q.push_back(wv);
          done = 1'b1;
        end
        n++;
      end
      chk($sformatf("wrap write %0d completes", i), 32'(done), 32'h1);
      cyc(1'b1, NS, 1'b0, 4'h4, '0, 1'b0);
      cyc(1'b0, IDL, 1'b0, 4'h0, '0, 1'b0);
      chk($sformatf("wrap count %0d within depth", i), 32'(s_rdata[15:0] > 16'd4), 32'h0);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      cyc(1'b0, IDL, 1'b0, 4'h0, '0, 1'b1);
      n++;
    end
    chk("wrap drained", 32'(exp_q.size()), 32'h0);

    // asynchronous reset in the middle of a STATUS read data phase
    OUT_READY = 1'b0;
    drive(1'b1, NS, 1'b1, 4'h0, '0);
    @(posedge HCLK); #1;
    drive(1'b1, NS, 1'b0, 4'h4, 32'h0000_ABCD);
    @(posedge HCLK); #1;
    drive(1'b0, IDL, 1'b0, 4'h0, '0);
    @(negedge HCLK);
    chk("pre-reset status", bus.HRDATA, 32'h1);
    chk("pre-reset OUT_DATA", OUT_DATA, 32'h0000_ABCD);
    #1 HRESET = 1'b1;
    #1;
    chk("async reset HRDATA", bus.HRDATA, 32'h0);
    chk("async reset OUT_VALID", 32'(OUT_VALID), 32'h0);
    chk("async reset HREADYout", 32'(bus.HREADYout), 32'h1);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    drive(1'b1, NS, 1'b0, 4'h4, '0);
    @(posedge HCLK); #1;
    drive(1'b0, IDL, 1'b0, 4'h0, '0);
    @(negedge HCLK);
    chk("post-reset status", bus.HRDATA, 32'h0001_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
